// File: rtl/lfsr_prng_if.sv
// Handshake/bus bundle for lfsr_prng. The master drives control and seed, and the
// slave (the generator) returns the state, the handshake and the status flags.
interface lfsr_prng_if #(
  parameter int WIDTH = 9
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             out_ready;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             wrap;
  logic             lockup;
  logic [WIDTH-1:0] count;

  modport master (
    output en, load, seed_in, out_ready,
    input  data, out_valid, wrap, lockup, count
  );

  modport slave (
    input  en, load, seed_in, out_ready,
    output data, out_valid, wrap, lockup, count
  );
endinterface

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random generator with a ready/valid output handshake.
// The register advances only on an accepted step, so a stalled consumer never
// loses a value. Structure: MODE=0 selects Fibonacci, MODE=1 selects Galois.
// The generator spends one INIT cycle after reset and after each load, and
// holds out_valid low during that cycle. A zero seed would lock the register,
// so a zero seed is replaced by SEED and the sticky lockup flag is raised.
module lfsr_prng #(
  parameter int               WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(9'h110),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(9'h01F),
  parameter int               MODE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_prng_if.slave  bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             lockup_q;

  logic [WIDTH-1:0] step_val;
  logic             out_valid;
  logic             accept;

  // One-step successor of the current state, selected by MODE at elaboration.
  generate
    if (MODE == 0) begin : g_fib
      assign step_val = {data_q[WIDTH-2:0], ^(data_q & TAPS)};
    end else begin : g_gal
      assign step_val = {data_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{data_q[WIDTH-1]}} & TAPS);
    end
  endgenerate

  assign out_valid = (state_q == RUN) && bus.en;
  // Load takes priority over a step, so a step coinciding with load is not accepted.
  assign accept    = out_valid && bus.out_ready && !bus.load;

  // Control FSM and datapath, with priority rst > load > accepted step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      data_q   <= SEED;
      start_q  <= SEED;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (bus.load) begin
      state_q <= INIT;
      count_q <= '0;
      wrap_q  <= 1'b0;
      if (bus.seed_in == '0) begin
        data_q   <= SEED;
        start_q  <= SEED;
        lockup_q <= 1'b1;
      end else begin
        data_q  <= bus.seed_in;
        start_q <= bus.seed_in;
      end
    end else begin
      wrap_q <= 1'b0;
      if (state_q == INIT) state_q <= RUN;
      if (accept) begin
        data_q <= step_val;
        // On returning to the start value, the period counter restarts instead of counting on.
        if (step_val == start_q) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.out_valid = out_valid;
  assign bus.wrap      = wrap_q;
  assign bus.lockup    = lockup_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng covering the default Fibonacci build and a 4-bit Galois build.
module tb_lfsr_prng;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_prng_if #(.WIDTH(9)) b0 ();
  lfsr_prng_if #(.WIDTH(4)) b1 ();

  lfsr_prng u_fib (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  lfsr_prng #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1)) u_gal (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] hv [5]  = '{9'h03F, 9'h07F, 9'h0FF, 9'h1FF, 9'h1FE};
  logic [3:0] gv [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                          4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
  bit seen [512];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [8:0] fib9(input logic [8:0] d);
    return {d[7:0], d[8] ^ d[4]};
  endfunction

  initial begin
    logic [8:0] m;
    int         cnt;
    rst = 1'b1;
    b0.en = 1'b1; b0.out_ready = 1'b1; b0.load = 1'b0; b0.seed_in = '0;
    b1.en = 1'b0; b1.out_ready = 1'b0; b1.load = 1'b0; b1.seed_in = '0;
    tick;
    chk("rst_data",   b0.data,      9'h01F);
    chk("rst_count",  b0.count,     0);
    chk("rst_wrap",   b0.wrap,      0);
    chk("rst_lockup", b0.lockup,    0);
    chk("init_valid", b0.out_valid, 0);
    rst = 1'b0;
    tick;
    chk("run_valid", b0.out_valid, 1);
    chk("run_data0", b0.data,      9'h01F);

    // Full period: 511 accepted steps back to the seed.
    m = 9'h01F;
    seen[m] = 1'b1;
    for (int k = 1; k <= 511; k++) begin
      tick;
      m   = fib9(m);
      cnt = (k == 511) ? 0 : k;
      if (k <= 5) chk("vec_first", b0.data, hv[k-1]);
      chk("seq_data",  b0.data,  m);
      chk("seq_count", b0.count, cnt);
      chk("seq_wrap",  b0.wrap,  (k == 511));
      if (k < 511) begin
        chk("seq_nonzero", (b0.data != 0), 1);
        chk("seq_unique",  seen[b0.data], 0);
        seen[b0.data] = 1'b1;
      end
    end
    chk("wrap_data", b0.data, 9'h01F);

    // Stall mid-stream.
    repeat (3) tick;
    chk("pre_stall_data",  b0.data,  9'h0FF);
    chk("pre_stall_count", b0.count, 3);
    b0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_data",  b0.data,  9'h0FF);
      chk("stall_count", b0.count, 3);
      chk("stall_wrap",  b0.wrap,  0);
    end
    b0.out_ready = 1'b1;
    tick;
    chk("resume_data1",  b0.data,  9'h1FF);
    chk("resume_count1", b0.count, 4);
    tick;
    chk("resume_data2",  b0.data,  9'h1FE);
    chk("resume_count2", b0.count, 5);

    // en=0 drops out_valid and holds the state.
    b0.en = 1'b0;
    tick;
    chk("en0_valid", b0.out_valid, 0);
    chk("en0_data",  b0.data,      9'h1FE);
    b0.en = 1'b1;

    // Load a nonzero seed.
    b0.load = 1'b1; b0.seed_in = 9'h0AA;
    tick;
    chk("load_data",  b0.data,      9'h0AA);
    chk("load_count", b0.count,     0);
    chk("load_valid", b0.out_valid, 0);
    chk("load_wrap",  b0.wrap,      0);
    b0.load = 1'b0;
    tick;
    chk("postload_valid", b0.out_valid, 1);
    chk("postload_data",  b0.data,      9'h0AA);
    tick;
    chk("load_step_data",  b0.data,  9'h154);
    chk("load_step_count", b0.count, 1);

    // A zero seed is rejected even with en and out_ready low.
    b0.en = 1'b0; b0.out_ready = 1'b0;
    b0.load = 1'b1; b0.seed_in = 9'h000;
    tick;
    chk("zload_data",   b0.data,   9'h01F);
    chk("zload_lockup", b0.lockup, 1);
    chk("zload_count",  b0.count,  0);
    b0.load = 1'b0; b0.en = 1'b1; b0.out_ready = 1'b1;
    tick;
    tick;
    chk("zload_step",   b0.data,   9'h03F);
    chk("zload_sticky", b0.lockup, 1);
    b0.load = 1'b1; b0.seed_in = 9'h0AA;
    tick;
    chk("reload_data",   b0.data,   9'h0AA);
    chk("reload_lockup", b0.lockup, 1);
    b0.load = 1'b0;

    // Reset together with load: reset wins and clears lockup.
    rst = 1'b1; b0.load = 1'b1; b0.seed_in = 9'h055;
    tick;
    chk("rstload_data",   b0.data,      9'h01F);
    chk("rstload_lockup", b0.lockup,    0);
    chk("rstload_valid",  b0.out_valid, 0);
    chk("rstload_count",  b0.count,     0);
    rst = 1'b0; b0.load = 1'b0;

    // Galois build, period 15.
    b1.en = 1'b1; b1.out_ready = 1'b1;
    tick;
    chk("gal_valid", b1.out_valid, 1);
    chk("gal_data0", b1.data,      4'h1);
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("gal_data",  b1.data,  gv[i]);
      chk("gal_wrap",  b1.wrap,  (i == 14));
      chk("gal_count", b1.count, (i == 14) ? 0 : i + 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 Parameter WIDTH, default 9, sets the register width; the legal range is 3..32.
REQ-002 Parameter TAPS, default 9'h110 (x^9+x^5+1), is the WIDTH-bit feedback mask.
REQ-003 Parameter SEED, default 9'h01F, is the nonzero WIDTH-bit start value after reset.
REQ-004 Parameter MODE, default 0, selects the structure: 0 is Fibonacci, 1 is Galois.
REQ-005 clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 en, input, 1 bit: generator enable.
REQ-008 load, input, 1 bit: a one-cycle request to replace the state with seed_in.
REQ-009 seed_in, input, WIDTH bits: the value loaded when load=1.
REQ-010 out_ready, input, 1 bit: the consumer accepts data this cycle.
REQ-011 data, output, WIDTH bits: the current LFSR state, registered.
REQ-012 out_valid, output, 1 bit: data is offered to the consumer.
REQ-013 wrap, output, 1 bit: a one-cycle pulse when the sequence returns to its start value.
REQ-014 lockup, output, 1 bit: sticky flag indicating that an all-zero seed was rejected.
REQ-015 count, output, WIDTH bits: number of accepted steps since the last reset or load.

Function
REQ-016 Legality: MODE=0 requires TAPS[WIDTH-1]=1, and MODE=1 requires TAPS[0]=1; other TAPS values are illegal and their behaviour is undefined.
REQ-017 Fibonacci step (MODE=0): fb = XOR-reduce(data & TAPS); next = {data[WIDTH-2:0], fb}.
REQ-018 Galois step (MODE=1): next = {data[WIDTH-2:0], 1'b0} XOR ({WIDTH{data[WIDTH-1]}} & TAPS).
REQ-019 Control FSM states: INIT and RUN; the block SHALL be in INIT for exactly one cycle after reset and for exactly one cycle after each load.
REQ-020 FSM transitions: INIT always goes to RUN; RUN goes to INIT on load, otherwise stays in RUN.
REQ-021 out_valid = (FSM==RUN) & en, combinationally; it SHALL be 0 in INIT regardless of en.
REQ-022 Accepted step: out_valid & out_ready & !load; the state advances one step at that edge, with single-cycle latency.
REQ-023 With no accepted step, data SHALL hold its value; stalls (out_ready=0) SHALL never drop or skip a value.
REQ-024 Priority at each edge: rst > load > accepted step.
REQ-025 Load, nonzero seed_in: data<=seed_in, start<=seed_in, count<=0; load SHALL be honoured in INIT or RUN, regardless of en and out_ready.
REQ-026 Load, seed_in==0: data<=SEED, start<=SEED, count<=0, lockup<=1; the all-zero state SHALL never be entered.
REQ-027 start is an internal WIDTH-bit register holding the value of data at the last reset or load.
REQ-028 On each accepted step, count increments modulo 2^WIDTH.
REQ-029 wrap SHALL be 1 in the cycle after an accepted step whose next value equals start; the same step resets count to 0 instead of incrementing it.
REQ-030 wrap SHALL be 0 in every other cycle, including load and INIT cycles.
REQ-031 For a maximal-length TAPS, wrap SHALL occur every 2^WIDTH-1 accepted steps.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set: data=SEED, start=SEED, count=0, wrap=0, lockup=0, FSM=INIT.
REQ-033 rst SHALL clear lockup; load SHALL never clear lockup.
REQ-034 Asserting rst mid-stream, including during a stall or together with load, SHALL discard all progress and apply REQ-032.
REQ-035 All outputs SHALL be defined and free of X from the first edge at which rst=1.

Verification
REQ-036 Default parameters, rst for 1 cycle, then en=1 and out_ready=1: out_valid=0 for one cycle, then data SHALL read 0x01F, 0x03F, 0x07F, 0x0FF, 0x1FF, 0x1FE on consecutive cycles.
REQ-037 Run the defaults for 511 accepted steps: wrap pulses once, with data=0x01F and count=0 in that cycle; no value repeats and none is zero before the pulse.
REQ-038 Hold out_ready=0 for 5 cycles mid-stream: data and count SHALL be held; after release the sequence SHALL resume with the next value, none lost.
REQ-039 load=1 with seed_in=0x0AA: the next cycle SHALL show data=0x0AA, count=0, out_valid=0; the cycle after SHALL show out_valid=en.
REQ-040 load=1 with seed_in=0: data=0x01F and lockup=1; lockup SHALL persist through later loads and clear only on rst.
REQ-041 MODE=1, WIDTH=4, TAPS=4'h3, SEED=4'h1: the sequence SHALL be 1, 2, 4, 8, 3, 6, C, B, 5, A, 7, E, F, D, 9, then 1 with wrap=1 (period 15).
